// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V decode stage with valid/ready handshake, immediate generation and illegal-instruction counter
module decode_stage #(
  parameter int XLEN = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [4:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       imm_type,
  output logic             rd_we,
  output logic             rs1_used,
  output logic             rs2_used,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  logic [4:0] op;
  logic [2:0] f3, ty;
  logic we, u1, u2, known, ill;
  logic [31:0] i32;
  logic [XLEN-1:0] imm_d;
  assign op = in_instr[6:2];
  assign f3 = in_instr[14:12];
  assign in_ready = !out_valid || out_ready;
  always_comb begin
    ty = 3'd0;
    we = 1'b0;
    u1 = 1'b0;
    u2 = 1'b0;
    known = 1'b1;
    case (op)
      5'b01101, 5'b00101:          begin ty = 3'd4; we = 1'b1; end
      5'b11011:                    begin ty = 3'd5; we = 1'b1; end
      5'b11001, 5'b00000, 5'b00100: begin ty = 3'd1; we = 1'b1; u1 = 1'b1; end
      5'b11000:                    begin ty = 3'd3; u1 = 1'b1; u2 = 1'b1; end
      5'b01000:                    begin ty = 3'd2; u1 = 1'b1; u2 = 1'b1; end
      5'b01100:                    begin we = 1'b1; u1 = 1'b1; u2 = 1'b1; end
      5'b00011:                    known = 1'b1;
      5'b11100:                    ty = 3'd1;
      default:                     known = 1'b0;
    endcase
  end
  assign ill = in_instr[1:0] != 2'b11 || !known
    || (op == 5'b11001 && f3 != 3'd0)
    || (op == 5'b11000 && f3[2:1] == 2'b01)
    || (op == 5'b00000 && (f3 == 3'd7 || (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6))))
    || (op == 5'b01000 && f3 > (XLEN == 32 ? 3'd2 : 3'd3));
  // every format is built as a signed 32-bit value, then widened with its sign
  assign i32 = ty == 3'd1 ? {{20{in_instr[31]}}, in_instr[31:20]}
             : ty == 3'd2 ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
             : ty == 3'd3 ? {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
             : ty == 3'd4 ? {in_instr[31:12], 12'b0}
             : ty == 3'd5 ? {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
             : 32'd0;
  assign imm_d = ill ? '0 : XLEN'($signed(i32));
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      rs1 <= '0;
      rs2 <= '0;
      rd <= '0;
      opcode <= '0;
      funct3 <= '0;
      funct7 <= '0;
      imm <= '0;
      imm_type <= '0;
      rd_we <= 1'b0;
      rs1_used <= 1'b0;
      rs2_used <= 1'b0;
      illegal <= 1'b0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      rs1 <= in_instr[19:15];
      rs2 <= in_instr[24:20];
      rd <= in_instr[11:7];
      opcode <= op;
      funct3 <= f3;
      funct7 <= in_instr[31:25];
      imm <= imm_d;
      imm_type <= ill ? 3'd0 : ty;
      rd_we <= !ill && we && in_instr[11:7] != 5'd0;
      rs1_used <= !ill && u1;
      rs2_used <= !ill && u2;
      illegal <= ill;
      if (ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with a queue-based scoreboard over XLEN=32, XLEN=64 and CNT_W=2 instances
module tb_decode_stage;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [63:0] in_pc64;
  assign in_pc64 = {32'h1, in_pc};
  always #5 clk = ~clk;

  logic in_ready, out_valid, rd_we, rs1_used, rs2_used, illegal;
  logic [31:0] out_pc, imm;
  logic [4:0] rs1, rs2, rd, opcode;
  logic [2:0] funct3, imm_type;
  logic [6:0] funct7;
  logic [7:0] illegal_cnt;

  logic in_ready64, out_valid64, rd_we64, rs1_used64, rs2_used64, illegal64;
  logic [63:0] out_pc64, imm64;
  logic [4:0] rs1_64, rs2_64, rd_64, opcode64;
  logic [2:0] funct3_64, imm_type64;
  logic [6:0] funct7_64;
  logic [7:0] illegal_cnt64;

  logic in_readyc, out_validc, rd_wec, rs1_usedc, rs2_usedc, illegalc;
  logic [31:0] out_pcc, immc;
  logic [4:0] rs1c, rs2c, rdc, opcodec;
  logic [2:0] funct3c, imm_typec;
  logic [6:0] funct7c;
  logic [1:0] illegal_cntc;

  decode_stage #(.XLEN(32), .CNT_W(8)) dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imm(imm), .imm_type(imm_type), .rd_we(rd_we), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .illegal(illegal), .illegal_cnt(illegal_cnt));
  decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64), .out_valid(out_valid64), .out_ready(out_ready),
    .out_pc(out_pc64), .rs1(rs1_64), .rs2(rs2_64), .rd(rd_64), .opcode(opcode64), .funct3(funct3_64),
    .funct7(funct7_64), .imm(imm64), .imm_type(imm_type64), .rd_we(rd_we64), .rs1_used(rs1_used64),
    .rs2_used(rs2_used64), .illegal(illegal64), .illegal_cnt(illegal_cnt64));
  decode_stage #(.XLEN(32), .CNT_W(2)) dutc (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(in_readyc), .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_validc), .out_ready(out_ready),
    .out_pc(out_pcc), .rs1(rs1c), .rs2(rs2c), .rd(rdc), .opcode(opcodec), .funct3(funct3c), .funct7(funct7c),
    .imm(immc), .imm_type(imm_typec), .rd_we(rd_wec), .rs1_used(rs1_usedc), .rs2_used(rs2_usedc),
    .illegal(illegalc), .illegal_cnt(illegal_cntc));

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  ty;
    logic        we, u1, u2, i32, i64;
  } vec_t;
  typedef struct {
    int idx;
    logic [31:0] pc;
    int c32, c64;
  } exp_t;

  // imm is the raw immediate; expected output imm is 0 for the XLEN where the encoding is illegal
  vec_t vec [17] = '{
    '{32'h00310463, 32'h00000008, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h00110223, 32'h00000004, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'h800000B7, 32'h80000000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h00000000, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{32'h000110E7, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{32'hFFF00293, 32'hFFFFFFFF, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0},
    '{32'h00208033, 32'h00000000, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'h00013083, 32'h00000000, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'h00113423, 32'h00000008, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
    '{32'h0000000F, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h00000073, 32'h00000000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h12345197, 32'h12345000, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h00017083, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{32'h0000007F, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{32'h00312463, 32'h00000000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
    '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}
  };

  exp_t q[$];
  int checks = 0, errors = 0, c32 = 0, c64 = 0;
  logic [31:0] pc = 32'h1000;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic logic [6:0] ctl(input vec_t v, input logic il);
    return il ? 7'b1000000 : {1'b0, v.ty, v.we, v.u1, v.u2};
  endfunction

  exp_t me;
  vec_t mv;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 64'd1, 64'd0);
      else begin
        me = q.pop_front();
        mv = vec[me.idx];
        chk("pc", out_pc, me.pc);
        chk("fields", {rs1, rs2, rd, opcode, funct3, funct7},
            {mv.instr[19:15], mv.instr[24:20], mv.instr[11:7], mv.instr[6:2], mv.instr[14:12], mv.instr[31:25]});
        chk("imm", imm, mv.i32 ? 32'd0 : mv.imm);
        chk("ctl", {illegal, imm_type, rd_we, rs1_used, rs2_used}, ctl(mv, mv.i32));
        chk("cnt", illegal_cnt, me.c32);
        chk("valid64", out_valid64, 1'b1);
        chk("pc64", out_pc64, {32'h1, me.pc});
        chk("imm64", imm64, mv.i64 ? 64'd0 : {{32{mv.imm[31]}}, mv.imm});
        chk("ctl64", {illegal64, imm_type64, rd_we64, rs1_used64, rs2_used64}, ctl(mv, mv.i64));
        chk("cnt64", illegal_cnt64, me.c64);
        chk("validc", out_validc, 1'b1);
        chk("cnt_sat", illegal_cntc, me.c32 > 3 ? 2'd3 : me.c32[1:0]);
      end
    end
  end

  task automatic send(input int i);
    int n = 0;
    bit took = 0;
    in_valid = 1;
    in_instr = vec[i].instr;
    in_pc = pc;
    while (!took && n < 20) begin
      @(negedge clk);
      took = in_ready && !flush;
      if (out_ready) chk("in_ready_free", in_ready, 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!took) chk("send_timeout", 64'd0, 64'd1);
    else begin
      c32 += vec[i].i32;
      c64 += vec[i].i64;
      q.push_back('{i, pc, c32, c64});
      pc += 4;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [70:0] snap;
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_cnt", illegal_cnt, 8'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_ctl", {illegal, imm_type, rd_we, rs1_used, rs2_used}, 7'd0);
    @(posedge clk);
    #1 out_ready = 1;
    for (int i = 0; i < 4; i++) send(i);
    // hold lui under backpressure while the next instruction waits
    out_ready = 0;
    in_valid = 1;
    in_instr = vec[6].instr;
    in_pc = pc;
    @(negedge clk);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_imm", imm, 32'h80000000);
    snap = {imm, out_pc, illegal, imm_type, rd_we, rs1_used, rs2_used};
    repeat (2) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_hold", {imm, out_pc, illegal, imm_type, rd_we, rs1_used, rs2_used}, snap);
    end
    @(posedge clk);
    #1 out_ready = 1;
    send(6);
    send(4);
    send(5);
    for (int i = 7; i < 17; i++) send(i);
    idle(3);
    chk("cnt_after_stream", illegal_cnt, 8'd7);
    chk("cnt_sat_stream", illegal_cntc, 2'd3);
    // flush drops a held bundle
    send(0);
    out_ready = 0;
    flush = 1;
    in_valid = 1;
    in_instr = vec[4].instr;
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    q.delete();
    @(negedge clk);
    chk("flush1_valid", out_valid, 1'b0);
    chk("flush1_cnt", illegal_cnt, 8'd7);
    // flush drops an incoming instruction that would otherwise load
    @(posedge clk);
    #1 out_ready = 1;
    flush = 1;
    in_valid = 1;
    in_instr = vec[5].instr;
    @(posedge clk);
    #1 flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("flush2_valid", out_valid, 1'b0);
    chk("flush2_cnt", illegal_cnt, 8'd7);
    chk("flush2_cnt64", illegal_cnt64, 8'd5);
    @(posedge clk);
    #1;
    send(1);
    send(2);
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    q.delete();
    c32 = 0;
    c64 = 0;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_cnt", illegal_cnt, 8'd0);
    chk("mid_rst_cnt64", illegal_cnt64, 8'd0);
    chk("mid_rst_cntc", illegal_cntc, 2'd0);
    @(posedge clk);
    #1;
    send(4);
    idle(3);
    chk("drained", q.size(), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Parametrised, registered RISC-V instruction decode stage sitting between fetch and register-read/execute.
- Accepts one 32-bit instruction plus PC per cycle on a valid/ready handshake.
- Produces register indices, opcode fields, a fully sign-extended XLEN-wide immediate for all formats (I/S/B/U/J), control hints and an illegal-instruction flag one cycle later.
- Supports flush and keeps a saturating illegal-instruction counter for debug.

Parameters:
- XLEN, 32, datapath width of pc and imm; legal values 32 or 64.
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  drop the held and incoming instruction
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_pc  out  XLEN  registered in_pc
- rs1, rs2, rd  out  5 each  instr[19:15], [24:20], [11:7]
- opcode  out  5  instr[6:2]
- funct3  out  3  instr[14:12]
- funct7  out  7  instr[31:25]
- imm  out  XLEN  sign-extended immediate
- imm_type  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
- rd_we  out  1  instruction writes rd, and rd != 0
- rs1_used, rs2_used  out  1 each  operand read required
- illegal  out  1  instruction not supported
- illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset: out_valid=0, illegal_cnt=0, all other registered outputs 0. in_ready=1 in the cycle after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer-in occurs when in_valid && in_ready.
  - Transfer-out occurs when out_valid && out_ready.
- Latency is 1 cycle and full throughput is 1 instruction/cycle under continuous out_ready.
- Output hold: while out_valid && !out_ready, all out_* fields stay stable.
- Flush:
  - On flush=1 the next-cycle out_valid=0 and no transfer-in is registered.
  - The counter is not incremented.
  - Flush has priority over transfer-in and over rst=0 activity.
  - rst has priority over flush.
- Register load: on transfer-in, all outputs are captured from in_instr/in_pc. Without transfer-in and with transfer-out, out_valid goes to 0.
- Immediate generation, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}, sign-extended above bit 31 when XLEN=64
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- Opcode map (opcode → format, rd_we/rs1_used/rs2_used):
  - LUI 01101 → U, 1/0/0
  - AUIPC 00101 → U, 1/0/0
  - JAL 11011 → J, 1/0/0
  - JALR 11001 → I, 1/1/0
  - BRANCH 11000 → B, 0/1/1
  - LOAD 00000 → I, 1/1/0
  - STORE 01000 → S, 0/1/1
  - OP_IMM 00100 → I, 1/1/0
  - OP 01100 → none, 1/1/1
  - MISC_MEM 00011 → none, 0/0/0
  - SYSTEM 11100 → I, 0/0/0
- rd_we is forced to 0 when rd == 0.
- Illegal when any of the following holds:
  - instr[1:0] != 2'b11
  - opcode not in the map
  - JALR with funct3 != 0
  - BRANCH with funct3 = 010 or 011
  - LOAD with funct3 = 111, or with funct3 = 011 or 110 when XLEN=32
  - STORE with funct3 > 010 when XLEN=32, or > 011 when XLEN=64
- When illegal=1: rd_we=0, rs1_used=0, rs2_used=0, imm=0, imm_type=0. Field outputs (rs1, rd, etc.) still reflect raw bits.
- illegal_cnt increments by 1 on each transfer-in with illegal=1 and saturates at 2^CNT_W-1.

Test Plan:
- Reset, then beq x2,x3,+8 (0x00310463), out_ready=1 → next cycle out_valid=1, rs1=2, rs2=3, imm=0x00000008, imm_type=3, rd_we=0, rs2_used=1, illegal=0.
- jal x1,-4 (0xFFDFF0EF), then sb x1,4(x2) (0x00110223) on back-to-back cycles → imm=0xFFFFFFFC, imm_type=5, rd_we=1, rd=1; next cycle imm=0x00000004, imm_type=2, rd_we=0; in_ready stays 1 throughout.
- XLEN=64: lui x1,0x80000 (0x800000B7) → imm=0xFFFFFFFF80000000, imm_type=4.
- Backpressure: out_ready=0 for 3 cycles with in_valid held → in_ready=0, outputs frozen. Raising out_ready → held bundle retires, new instruction loads the next cycle, nothing lost or duplicated.
- 0x00000000 and jalr with funct3=001 (0x000110E7) → illegal=1, rd_we=0, illegal_cnt=2. With CNT_W=2, six illegal instructions → illegal_cnt=3.
- Flush while out_valid=1 and in_valid=1 → next cycle out_valid=0, illegal_cnt unchanged. rst asserted mid-stream → out_valid=0, illegal_cnt=0.
